// File: rtl/mc_maindec_pkg.sv
// rtl/mc_maindec_pkg.sv - shared opcodes, state enumeration and control encodings for mc_maindec
// Optional feature macro: MC_ADDI_EN (adds the addi states and decode)
package mc_maindec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
`ifdef MC_ADDI_EN
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`endif
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic     iord;
    logic     irwrite;
    logic     pcwrite;
    logic     branch;
    logic     memwrite;
    logic     regwrite;
    logic     regdst;
    logic     memtoreg;
    logic     alusrca;
    alusrcb_t alusrcb;
    pcsrc_t   pcsrc;
    aluop_t   aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_maindec_if.sv
// rtl/mc_maindec_if.sv - opcode/handshake inputs and control outputs of the main decoder
interface mc_maindec_if;

  logic [5:0] op;
  logic       mem_ready;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal;

  modport master (
    input  op, mem_ready,
    output iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal
  );

  modport slave (
    output op, mem_ready,
    input  iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal
  );

endinterface

// File: rtl/mc_ctrl_rom.sv
// rtl/mc_ctrl_rom.sv - pure state-to-control-word decode for the multicycle main decoder
// Optional feature macro: MC_ADDI_EN (decodes the addi states)
module mc_ctrl_rom
  import mc_maindec_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
      end
`ifdef MC_ADDI_EN
      S_MEMADR, S_ADDIEX: begin
`else
      S_MEMADR: begin
`endif
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - multicycle main decoder FSM: state register, sequencing, mem_ready qualification
// Optional feature macro: MC_ADDI_EN (addi support; otherwise op=001000 is illegal)
module mc_maindec
  import mc_maindec_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mc_maindec_if.master  bus
);

  state_t state;
  state_t state_n;
  ctrl_t  ctrl;
  logic   illegal_op;
  logic   fetch_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: if (bus.mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_BEQ:       state_n = S_BRANCH;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_n = S_ADDIEX;
`endif
          OP_J:         state_n = S_JUMP;
          default: begin
            state_n    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_n = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_n = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_n = S_FETCH;
      S_EXECUTE: state_n = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX:  state_n = S_ADDIWB;
`endif
      default:   state_n = S_FETCH;
    endcase
  end

  mc_ctrl_rom u_rom (
    .state (state),
    .ctrl  (ctrl)
  );

  // A stalled fetch must not advance PC/IR; reset also masks every write strobe.
  assign fetch_stall = (state == S_FETCH) && !bus.mem_ready;

  assign bus.iord     = ctrl.iord;
  assign bus.irwrite  = ctrl.irwrite  & ~fetch_stall & ~reset;
  assign bus.pcwrite  = ctrl.pcwrite  & ~fetch_stall & ~reset;
  assign bus.branch   = ctrl.branch   & ~reset;
  assign bus.memwrite = ctrl.memwrite & ~reset;
  assign bus.regwrite = ctrl.regwrite & ~reset;
  assign bus.regdst   = ctrl.regdst;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.pcsrc    = ctrl.pcsrc;
  assign bus.aluop    = ctrl.aluop;
  assign bus.illegal  = illegal_op & ~reset;

endmodule

// File: tb/tb_mc_maindec.sv
// tb/tb_mc_maindec.sv - directed self-checking bench for mc_maindec
module tb_mc_maindec;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mc_maindec_if bus ();

  mc_maindec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {iord,irwrite,pcwrite,branch,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluop,illegal}
  logic [15:0] obs;
  assign obs = {bus.iord, bus.irwrite, bus.pcwrite, bus.branch, bus.memwrite,
                bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
                bus.alusrcb, bus.pcsrc, bus.aluop, bus.illegal};

  localparam logic [15:0] W_FETCH  = {9'b011000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_STALL  = {9'b000000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_DECODE = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_ILL    = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [15:0] W_MEMADR = {9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMRD  = {9'b100000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMWB  = {9'b000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMWR  = {9'b100010000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_EXEC   = {9'b000000001, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [15:0] W_ALUWB  = {9'b000001100, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_BRANCH = {9'b000100001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [15:0] W_JUMP   = {9'b001000000, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] W_ADDIWB = {9'b000001000, 2'b00, 2'b00, 2'b00, 1'b0};

  task automatic chk(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.op        = 6'b000000;
    bus.mem_ready = 1'b1;

    #1 chk("reset_t0", W_STALL);
    cyc();
    cyc();
    chk("reset_held", W_STALL);
    reset = 1'b0;
    #1 chk("fetch_after_reset", W_FETCH);

    // lw with mem_ready tied high: 5 cycles
    bus.op = 6'b100011;
    cyc(); chk("lw_decode", W_DECODE);
    cyc(); chk("lw_memadr", W_MEMADR);
    cyc(); chk("lw_memrd", W_MEMRD);
    cyc(); chk("lw_memwb", W_MEMWB);
    cyc(); chk("lw_fetch", W_FETCH);

    // stalled fetch keeps PC/IR quiet
    bus.mem_ready = 1'b0;
    #1 chk("fetch_stall_1", W_STALL);
    cyc(); chk("fetch_stall_2", W_STALL);

    // sw with three stall cycles in MEMWR
    bus.op        = 6'b101011;
    bus.mem_ready = 1'b1;
    #1 chk("sw_fetch", W_FETCH);
    cyc(); chk("sw_decode", W_DECODE);
    cyc(); chk("sw_memadr", W_MEMADR);
    bus.mem_ready = 1'b0;
    cyc(); chk("sw_memwr_1", W_MEMWR);
    cyc(); chk("sw_memwr_2", W_MEMWR);
    cyc(); chk("sw_memwr_3", W_MEMWR);
    cyc();
    bus.mem_ready = 1'b1;
    #1 chk("sw_memwr_4", W_MEMWR);
    cyc(); chk("sw_fetch_after", W_FETCH);

    // R-type
    bus.op = 6'b000000;
    cyc(); chk("r_decode", W_DECODE);
    cyc(); chk("r_execute", W_EXEC);
    cyc(); chk("r_aluwb", W_ALUWB);
    cyc(); chk("r_fetch", W_FETCH);

    // beq
    bus.op = 6'b000100;
    cyc(); chk("beq_decode", W_DECODE);
    cyc(); chk("beq_branch", W_BRANCH);
    cyc(); chk("beq_fetch", W_FETCH);

    // unsupported opcode
    bus.op = 6'b111111;
    cyc(); chk("ill_decode", W_ILL);
    cyc(); chk("ill_fetch", W_FETCH);

    // addi: legal only when the option is built in
    bus.op = 6'b001000;
`ifdef MC_ADDI_EN
    cyc(); chk("addi_decode", W_DECODE);
    cyc(); chk("addi_ex", W_MEMADR);
    cyc(); chk("addi_wb", W_ADDIWB);
    cyc(); chk("addi_fetch", W_FETCH);
`else
    cyc(); chk("addi_illegal", W_ILL);
    cyc(); chk("addi_fetch", W_FETCH);
`endif

    // reset asynchronously during a MEMRD stall
    bus.op = 6'b100011;
    cyc(); chk("rst_lw_decode", W_DECODE);
    cyc(); chk("rst_lw_memadr", W_MEMADR);
    bus.mem_ready = 1'b0;
    cyc(); chk("rst_memrd_1", W_MEMRD);
    cyc(); chk("rst_memrd_2", W_MEMRD);
    #2 reset = 1'b1;
    #1 chk("rst_async", W_STALL);
    bus.mem_ready = 1'b1;
    #1 chk("rst_async_ready", W_STALL);
    cyc();
    reset  = 1'b0;
    bus.op = 6'b000010;
    #1 chk("rst_release_fetch", W_FETCH);
    cyc(); chk("rst_first_edge", W_DECODE);
    cyc(); chk("j_jump", W_JUMP);
    cyc(); chk("j_fetch", W_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
